// File: rtl/adder_tree_frame_loader_pkg.sv
// Shared constants, width helper and result-entry type for the adder-tree frame loader.
package adder_tree_pkg;

  localparam int LANES     = 8;
  localparam int TREE_LAT  = 3;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ID_W  = 8;

  // Width of a signed sum of LANES samples of width w; large enough that no overflow is possible.
  function automatic int sum_w(input int w);
    return w + $clog2(LANES);
  endfunction

  // One result FIFO entry for the default configuration: frame id plus its sum.
  typedef struct packed {
    logic [DEF_ID_W-1:0]           id;
    logic [sum_w(DEF_WIDTH)-1:0]   sum;
  } result_t;

endpackage

// File: rtl/adder_tree_frame_loader_sum_result_fifo.sv
// Small synchronous FIFO for frame results; head entry is visible combinationally.
module sum_result_fifo
  import adder_tree_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 19
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [DATA_W-1:0]            din,
  input  logic                         pop,
  output logic [DATA_W-1:0]            dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              do_push, do_pop;

  // Pointer/occupancy update; a push and a pop in the same cycle both happen, even when full.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    occ_d   = occ_q;
    do_pop  = pop && (occ_q != '0);
    do_push = push && ((occ_q != OCC_W'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (do_pop && !do_push) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);
  assign occ   = occ_q;

endmodule

// File: rtl/adder_tree_frame_loader.sv
// Collects 8-sample frames, launches them into a fixed-latency sum tree and queues the sums.
module adder_tree_frame_loader
  import adder_tree_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int TREE_LAT = adder_tree_pkg::TREE_LAT,
  parameter int ID_W     = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_data,
  output logic [LANES*WIDTH-1:0]    lanes_o,
  input  logic [sum_w(WIDTH)-1:0]   tree_sum_i,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [sum_w(WIDTH)-1:0]   m_sum,
  output logic [ID_W-1:0]           m_id
);

  localparam int SUM_W = sum_w(WIDTH);
  localparam int ENT_W = ID_W + SUM_W;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                     run_q, run_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [WIDTH-1:0]         buf_q [LANES-1];
  logic [WIDTH-1:0]         buf_d [LANES-1];
  logic [LANES*WIDTH-1:0]   lanes_q, lanes_d;
  logic [TREE_LAT:0]        infl_q, infl_d;
  logic [ID_W-1:0]          id_q, id_d;

  logic [OCC_W-1:0]         occ;
  logic                     fifo_full, fifo_empty;
  logic [ENT_W-1:0]         head;
  logic [31:0]              pending;
  logic                     credit, accept, launch, capture, push, pop;

  // Credit: every frame in the tree, plus every queued result, must fit in the FIFO.
  always_comb begin
    pending = 32'(occ);
    for (int i = 0; i <= TREE_LAT; i++) pending = pending + 32'(infl_q[i]);
    credit = (pending < 32'(DEPTH));
  end

  // The last lane is only offered when a FIFO slot is guaranteed; s_ready is held low in reset's wake.
  assign s_ready = run_q && !clr && ((cnt_q != 3'd7) || credit);
  assign accept  = s_valid && s_ready;
  assign launch  = accept && (cnt_q == 3'd7);

  // Frame collection: buffer lanes 0..6, then present all eight lanes at once on the final sample.
  always_comb begin
    run_d   = 1'b1;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    lanes_d = lanes_q;
    if (clr) begin
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == 3'd7) begin
        cnt_d = '0;
        for (int k = 0; k < LANES - 1; k++) lanes_d[k*WIDTH +: WIDTH] = buf_q[k];
        lanes_d[(LANES-1)*WIDTH +: WIDTH] = s_data;
      end else begin
        buf_d[cnt_q] = s_data;
        cnt_d        = cnt_q + 3'd1;
      end
    end
  end

  // In-flight tracking: a launch bit walks TREE_LAT stages; at the last stage the tree sum is valid.
  always_comb begin
    infl_d  = {infl_q[TREE_LAT-1:0], launch};
    capture = infl_q[TREE_LAT];
    push    = capture && (!fifo_full || pop);
    id_d    = push ? id_q + ID_W'(1) : id_q;
  end

  // Loader state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < LANES - 1; k++) buf_q[k] <= '0;
      lanes_q <= '0;
      infl_q  <= '0;
      id_q    <= '0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      lanes_q <= lanes_d;
      infl_q  <= infl_d;
      id_q    <= id_d;
    end
  end

  assign pop = !fifo_empty && m_ready;

  sum_result_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   ({id_q, tree_sum_i}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .occ   (occ)
  );

  assign lanes_o        = lanes_q;
  assign m_valid        = !fifo_empty;
  assign {m_id, m_sum}  = head;

endmodule
